// File: rtl/ecc_scrub_scheduler.sv
// Round-robin scheduler for per-bank ECC scrubbers: paces scrub steps by an idle
// interval, skips busy banks, aborts stalled steps and keeps saturating error counts.
module ecc_scrub_scheduler #(
    parameter int NumBanks      = 4,
    parameter int CntWidth      = 16,
    parameter int TimeoutCycles = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic [CntWidth-1:0]         interval_i,
    input  logic                        clear_i,
    input  logic [NumBanks-1:0]         bank_busy_i,
    input  logic [NumBanks-1:0]         step_done_i,
    input  logic [NumBanks-1:0]         corrected_i,
    input  logic [NumBanks-1:0]         uncorrectable_i,
    output logic [NumBanks-1:0]         scrub_trigger_o,
    output logic [$clog2(NumBanks)-1:0] active_bank_o,
    output logic [CntWidth-1:0]         corrected_cnt_o,
    output logic [CntWidth-1:0]         uncorrectable_cnt_o,
    output logic                        irq_o,
    output logic                        timeout_o
);

    localparam int IdxW  = $clog2(NumBanks);
    localparam int StepW = $clog2(TimeoutCycles);
    localparam logic [StepW-1:0] StepLast = StepW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0]  BankLast = IdxW'(NumBanks - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SCRUB
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] timer_q, timer_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     sel_q, sel_d;
    logic [StepW-1:0]    step_q, step_d;
    logic [IdxW-1:0]     cand, pick;
    logic                found;
    logic                done_sel;
    logic                in_scrub;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] b);
        return (b == BankLast) ? '0 : b + 1'b1;
    endfunction

    // Cyclic search starting at the round-robin pointer for the first idle bank.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < NumBanks; i++) begin
            if (!found && !bank_busy_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        ptr_d           = ptr_q;
        sel_d           = sel_q;
        step_d          = step_q;
        scrub_trigger_o = '0;
        timeout_o       = 1'b0;
        done_sel        = step_done_i[sel_q];
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    timer_d = interval_i;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (found) begin
                    sel_d   = pick;
                    step_d  = '0;
                    state_d = SCRUB;
                end
            end
            SCRUB: begin
                // The trigger is held regardless of enable_i; only done or abort ends a step.
                scrub_trigger_o[sel_q] = 1'b1;
                step_d                 = step_q + 1'b1;
                if (done_sel || step_q == StepLast) begin
                    timeout_o = !done_sel;
                    ptr_d     = wrap_inc(sel_q);
                    timer_d   = interval_i;
                    state_d   = enable_i ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_scrub      = (state_q == SCRUB);
    assign active_bank_o = sel_q;

    // Only the bank being scrubbed may report errors; clear overrides any same-cycle event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corrected_cnt_o     <= '0;
            uncorrectable_cnt_o <= '0;
            irq_o               <= 1'b0;
        end else if (clear_i) begin
            corrected_cnt_o     <= '0;
            uncorrectable_cnt_o <= '0;
            irq_o               <= 1'b0;
        end else begin
            if (in_scrub && corrected_i[sel_q]) begin
                corrected_cnt_o <= sat_inc(corrected_cnt_o);
            end
            if (in_scrub && uncorrectable_i[sel_q]) begin
                uncorrectable_cnt_o <= sat_inc(uncorrectable_cnt_o);
                irq_o               <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Scoreboard bench for ecc_scrub_scheduler: the driver predicts each scrub step
// (bank, gap, length, abort, counters) and a negedge monitor checks the DUT against it.
module tb_ecc_scrub_scheduler;

    localparam int NB = 4;
    localparam int CW = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enable;
    logic [CW-1:0] interval;
    logic          clear;
    logic [NB-1:0] busy, done, corr, unc;
    logic [NB-1:0] trig;
    logic [1:0]    active;
    logic [CW-1:0] corr_cnt, unc_cnt;
    logic          irq, tmo;

    ecc_scrub_scheduler #(
        .NumBanks      (NB),
        .CntWidth      (CW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .enable_i            (enable),
        .interval_i          (interval),
        .clear_i             (clear),
        .bank_busy_i         (busy),
        .step_done_i         (done),
        .corrected_i         (corr),
        .uncorrectable_i     (unc),
        .scrub_trigger_o     (trig),
        .active_bank_o       (active),
        .corrected_cnt_o     (corr_cnt),
        .uncorrectable_cnt_o (unc_cnt),
        .irq_o               (irq),
        .timeout_o           (tmo)
    );

    typedef struct {
        int bank;
        int gap;
        int len;
        bit to;
        int corr;
        int unc;
        bit irq;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int m_ptr  = 0;
    int m_corr = 0;
    int m_unc  = 0;
    bit m_irq  = 0;
    int m_iv   = 0;
    bit fresh  = 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per scrub step when the trigger first appears.
    logic [NB-1:0] mon_prev = '0;
    int            mon_len  = 0;
    int            mon_idle = 0;
    bit            mon_to   = 0;
    bit            mon_live = 0;
    exp_t          cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = '0;
            mon_len  = 0;
            mon_idle = 0;
            mon_to   = 0;
            mon_live = 0;
        end else begin
            if (trig != '0) begin
                if (mon_prev == '0) begin
                    mon_len = 1;
                    mon_to  = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_trigger", int'(trig), 0);
                        mon_live = 0;
                    end else begin
                        cur      = exp_q.pop_front();
                        mon_live = 1;
                        chk("trigger_bank", int'(trig), 1 << cur.bank);
                        chk("active_bank", int'(active), cur.bank);
                        if (cur.gap >= 0) chk("step_gap", mon_idle, cur.gap);
                        chk("corrected_cnt", int'(corr_cnt), cur.corr);
                        chk("uncorrectable_cnt", int'(unc_cnt), cur.unc);
                        chk("irq", int'(irq), int'(cur.irq));
                    end
                end else begin
                    chk("trigger_held", int'(trig), int'(mon_prev));
                    mon_len++;
                end
                if (tmo) begin
                    mon_to = 1;
                    if (mon_live) begin
                        chk("timeout_expected", int'(tmo), int'(cur.to));
                        chk("timeout_cycle", mon_len, TO);
                    end
                end
            end else begin
                if (tmo) chk("timeout_outside_scrub", int'(tmo), 0);
                if (mon_prev != '0 && mon_live) begin
                    if (cur.len >= 0) chk("step_len", mon_len, cur.len);
                    chk("step_aborted", int'(mon_to), int'(cur.to));
                    mon_live = 0;
                end
                mon_idle = (mon_prev != '0) ? 1 : mon_idle + 1;
            end
            mon_prev = trig;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_bank(input logic [NB-1:0] b);
        int idx;
        for (int i = 0; i < NB; i++) begin
            idx = (m_ptr + i) % NB;
            if (!b[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic apply_model(input int b);
        if (corr[b]) m_corr = sat(m_corr);
        if (unc[b]) begin
            m_unc = sat(m_unc);
            m_irq = 1;
        end
        if (clear) begin
            m_corr = 0;
            m_unc  = 0;
            m_irq  = 0;
        end
    endtask

    // Pulses that must be ignored outside SCRUB.
    task automatic noise();
        done  = NB'($urandom);
        corr  = NB'($urandom);
        unc   = NB'($urandom);
        clear = 1'b0;
    endtask

    task automatic wait_trig(output bit seen);
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            noise();
            tick();
            if (trig != '0) seen = 1;
        end
        if (!seen) chk("trigger_wait_bound", 0, 1);
    endtask

    // d<=0 means no done (abort expected). mode: 0 quiet, 1 random errors,
    // 2 two uncorrectables on sel + one elsewhere, 3 clear with same-cycle error, 4 corrected every cycle.
    task automatic do_step(input logic [NB-1:0] bz, input int d, input int mode,
                           input int next_iv, input bit drop_en, input int hold);
        exp_t          e;
        int            b;
        bit            seen;
        logic [NB-1:0] oh, other;
        b      = pick_bank(bz);
        e.bank = b;
        e.gap  = (fresh || hold > 0) ? -1 : m_iv + 1;
        e.to   = (d <= 0);
        e.len  = (d <= 0) ? TO : d;
        e.corr = m_corr;
        e.unc  = m_unc;
        e.irq  = m_irq;
        exp_q.push_back(e);
        fresh  = 0;
        oh     = NB'(1) << b;
        other  = NB'(1) << ((b + 1) % NB);
        if (hold > 0) begin
            busy = '1;
            repeat (hold) begin
                noise();
                tick();
            end
        end
        busy = bz;
        wait_trig(seen);
        if (!seen) return;
        for (int c = 1; c <= e.len; c++) begin
            done  = NB'($urandom) & ~oh;
            corr  = '0;
            unc   = '0;
            clear = 1'b0;
            case (mode)
                1: begin
                    corr  = NB'($urandom);
                    unc   = ($urandom_range(0, 9) == 0) ? NB'($urandom) : '0;
                    clear = ($urandom_range(0, 39) == 0);
                end
                2: if (c == 1) unc = oh | other; else if (c == 2) unc = oh;
                3: if (c == 1) begin
                    unc   = oh;
                    clear = 1'b1;
                end
                4: corr = oh;
                default: ;
            endcase
            if (d > 0 && c == d) done = done | oh;
            if (c == 1) begin
                interval = CW'(next_iv);
                if (drop_en) enable = 1'b0;
            end
            apply_model(b);
            tick();
        end
        done  = '0;
        corr  = '0;
        unc   = '0;
        clear = 1'b0;
        m_ptr = (b + 1) % NB;
        m_iv  = next_iv;
        if (drop_en) fresh = 1;
    endtask

    initial begin
        exp_t          e;
        bit            seen;
        logic [NB-1:0] bz;
        int            d;

        rst_n    = 1'b0;
        enable   = 1'b0;
        interval = '0;
        clear    = 1'b0;
        busy     = '0;
        done     = '0;
        corr     = '0;
        unc      = '0;
        repeat (3) tick();
        chk("reset_trigger", int'(trig), 0);
        chk("reset_active_bank", int'(active), 0);
        chk("reset_corrected_cnt", int'(corr_cnt), 0);
        chk("reset_uncorrectable_cnt", int'(unc_cnt), 0);
        chk("reset_irq", int'(irq), 0);
        chk("reset_timeout", int'(tmo), 0);
        rst_n = 1'b1;
        tick();

        // Plain round robin with a 3-cycle interval.
        interval = CW'(3);
        m_iv     = 3;
        enable   = 1'b1;
        repeat (5) do_step('0, 2, 0, 3, 0, 0);

        // Busy banks skipped from ptr=1, then a timed-out step on bank 2.
        do_step(4'b0110, 2, 0, 3, 0, 0);
        do_step('0, 2, 0, 3, 0, 0);
        do_step('0, 3, 0, 3, 0, 0);
        do_step('0, 0, 0, 3, 0, 0);
        do_step('0, 2, 0, 1, 0, 0);

        // Error counters, clear priority and saturation.
        do_step('0, 4, 2, 1, 0, 0);
        do_step('0, 3, 3, 0, 0, 0);
        do_step('0, 17, 4, 2, 0, 0);
        do_step('0, 1, 0, 0, 0, 0);

        // All banks busy for a while, then a partial release.
        do_step(4'b1011, 2, 0, 2, 0, 12);

        repeat (40) begin
            bz = NB'($urandom);
            if (&bz) bz[$urandom_range(0, NB - 1)] = 1'b0;
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            do_step(bz, d, 1, int'($urandom_range(0, 5)), 0, 0);
        end

        // Enable dropped during a step: step completes, then no more triggers.
        do_step('0, 4, 0, 2, 1, 0);
        repeat (30) begin
            noise();
            tick();
        end

        // Reset in the middle of a step.
        enable = 1'b1;
        busy   = '0;
        e.bank = pick_bank('0);
        e.gap  = -1;
        e.len  = -1;
        e.to   = 0;
        e.corr = m_corr;
        e.unc  = m_unc;
        e.irq  = m_irq;
        exp_q.push_back(e);
        wait_trig(seen);
        done = '0;
        corr = '0;
        unc  = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_trigger", int'(trig), 0);
        chk("midreset_timeout", int'(tmo), 0);
        chk("midreset_active_bank", int'(active), 0);
        chk("midreset_corrected_cnt", int'(corr_cnt), 0);
        chk("midreset_irq", int'(irq), 0);
        tick();
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (5) tick();
        chk("pending_expectations", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
